// File: rtl/avalon_cdc_pkg.sv
// Shared helpers for the Avalon-MM clock-crossing bridge:
// clog2 and the command-word field layout.
package avalon_cdc_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Command word, LSB first:
  // writedata | byteenable | address | write | read
  function automatic int cmd_w(input int aw, input int dw);
    return 2 + aw + dw / 8 + dw;
  endfunction

  function automatic int be_lsb(input int dw);
    return dw;
  endfunction

  function automatic int addr_lsb(input int dw);
    return dw + dw / 8;
  endfunction

  function automatic int wr_bit(input int aw, input int dw);
    return addr_lsb(dw) + aw;
  endfunction

  function automatic int rd_bit(input int aw, input int dw);
    return wr_bit(aw, dw) + 1;
  endfunction

endpackage

// File: rtl/avalon_cdc_async_fifo.sv
// Dual-clock FIFO, Gray pointers, show-ahead read, registered flags.
// Ports: w* write side (wclk/wrst_n), r* read side (rclk/rrst_n).
module avalon_cdc_async_fifo
  import avalon_cdc_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             winc,
  input  logic [WIDTH-1:0] wdata,
  output logic             wfull,
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rinc,
  output logic [WIDTH-1:0] rdata,
  output logic             rempty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW:0] wbin, wgray, wbin_nx, wgray_nx;
  logic [AW:0] rbin, rgray, rbin_nx, rgray_nx;
  logic [AW:0] rq [SYNC_STAGES];
  logic [AW:0] wq [SYNC_STAGES];
  logic [AW:0] rgray_s, wgray_s;
  logic        wpush, rpop;

  function automatic logic [AW:0] b2g(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  assign wpush    = winc & ~wfull;
  assign rpop     = rinc & ~rempty;
  assign wbin_nx  = wbin + (AW+1)'(wpush);
  assign rbin_nx  = rbin + (AW+1)'(rpop);
  assign wgray_nx = b2g(wbin_nx);
  assign rgray_nx = b2g(rbin_nx);
  assign rgray_s  = rq[SYNC_STAGES-1];
  assign wgray_s  = wq[SYNC_STAGES-1];

  assign rdata = mem[rbin[AW-1:0]];

  always_ff @(posedge wclk)
    if (wpush) mem[wbin[AW-1:0]] <= wdata;

  // Full: writer one lap ahead, seen as the
  // top two Gray bits inverted.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin  <= '0;
      wgray <= '0;
      wfull <= 1'b0;
    end else begin
      wbin  <= wbin_nx;
      wgray <= wgray_nx;
      wfull <= (wgray_nx ==
                {~rgray_s[AW:AW-1], rgray_s[AW-2:0]});
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) rq[i] <= '0;
    end else begin
      rq[0] <= rgray;
      for (int i = 1; i < SYNC_STAGES; i++) rq[i] <= rq[i-1];
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin   <= '0;
      rgray  <= '0;
      rempty <= 1'b1;
    end else begin
      rbin   <= rbin_nx;
      rgray  <= rgray_nx;
      rempty <= (rgray_nx == wgray_s);
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) wq[i] <= '0;
    end else begin
      wq[0] <= wgray;
      for (int i = 1; i < SYNC_STAGES; i++) wq[i] <= wq[i-1];
    end
  end

endmodule

// File: rtl/avalon_cdc_bridge.sv
// Avalon-MM clock-crossing bridge with read-credit flow control.
// Ports: slave_* (slave_clk domain), master_* (master_clk domain).
module avalon_cdc_bridge
  import avalon_cdc_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 24,
  parameter int CMD_DEPTH   = 16,
  parameter int RSP_DEPTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   slave_clk,
  input  logic                   slave_reset_n,
  input  logic                   master_clk,
  input  logic                   master_reset_n,
  input  logic [ADDR_W-1:0]      slave_address,
  input  logic [DATA_W/8-1:0]    slave_byteenable,
  input  logic                   slave_read,
  input  logic                   slave_write,
  input  logic [DATA_W-1:0]      slave_writedata,
  output logic                   slave_waitrequest,
  output logic [DATA_W-1:0]      slave_readdata,
  output logic                   slave_readdatavalid,
  output logic [clog2(RSP_DEPTH):0] slave_pending,
  output logic [ADDR_W+clog2(DATA_W/8)-1:0] master_address,
  output logic [DATA_W/8-1:0]    master_byteenable,
  output logic                   master_read,
  output logic                   master_write,
  output logic [DATA_W-1:0]      master_writedata,
  input  logic                   master_waitrequest,
  input  logic [DATA_W-1:0]      master_readdata,
  input  logic                   master_readdatavalid,
  output logic                   master_rsp_overflow
);

  localparam int BE_W  = DATA_W / 8;
  localparam int BS    = clog2(BE_W);
  localparam int PW    = clog2(RSP_DEPTH) + 1;
  localparam int MA_W  = ADDR_W + BS;
  localparam int CW    = cmd_w(ADDR_W, DATA_W);
  localparam int BE_L  = be_lsb(DATA_W);
  localparam int AD_L  = addr_lsb(DATA_W);
  localparam int WR_B  = wr_bit(ADDR_W, DATA_W);
  localparam int RD_B  = rd_bit(ADDR_W, DATA_W);

  logic          cmd_full, cmd_empty, cmd_acc, cmd_pop;
  logic          rd_acc, pend_full;
  logic [CW-1:0] cmd_in, head;
  logic          rsp_full, rsp_empty;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] head_addr;

  // Slave side: accept unless the command FIFO is
  // full or a read would exceed the credit limit.
  assign pend_full = (slave_pending == PW'(RSP_DEPTH));
  assign slave_waitrequest = cmd_full |
                             (slave_read & pend_full);
  assign cmd_acc = (slave_read | slave_write) &
                   ~slave_waitrequest;
  assign rd_acc  = slave_read & ~slave_waitrequest;

  // Read wins when both strobes are set.
  assign cmd_in = {slave_read,
                   slave_write & ~slave_read,
                   slave_address,
                   slave_byteenable,
                   slave_writedata};

  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n) begin
      slave_pending <= '0;
    end else begin
      unique case ({rd_acc, slave_readdatavalid})
        2'b10:   slave_pending <= slave_pending + 1'b1;
        2'b01:   slave_pending <= slave_pending - 1'b1;
        default: slave_pending <= slave_pending;
      endcase
    end
  end

  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n) begin
      slave_readdatavalid <= 1'b0;
      slave_readdata      <= '0;
    end else begin
      slave_readdatavalid <= ~rsp_empty;
      if (!rsp_empty) slave_readdata <= rsp_rdata;
    end
  end

  avalon_cdc_async_fifo #(
    .WIDTH       (CW),
    .DEPTH       (CMD_DEPTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_cmd_fifo (
    .wclk   (slave_clk),
    .wrst_n (slave_reset_n),
    .winc   (cmd_acc),
    .wdata  (cmd_in),
    .wfull  (cmd_full),
    .rclk   (master_clk),
    .rrst_n (master_reset_n),
    .rinc   (cmd_pop),
    .rdata  (head),
    .rempty (cmd_empty)
  );

  // Master side: the FIFO head drives the bus directly
  // and only advances once the downstream accepts.
  assign head_addr         = head[AD_L +: ADDR_W];
  assign master_read       = ~cmd_empty & head[RD_B];
  assign master_write      = ~cmd_empty & head[WR_B];
  assign master_address    = MA_W'(head_addr) << BS;
  assign master_byteenable = head[BE_L +: BE_W];
  assign master_writedata  = head[DATA_W-1:0];
  assign cmd_pop           = ~cmd_empty & ~master_waitrequest;

  always_ff @(posedge master_clk or negedge master_reset_n) begin
    if (!master_reset_n) begin
      master_rsp_overflow <= 1'b0;
    end else if (master_readdatavalid & rsp_full) begin
      master_rsp_overflow <= 1'b1;
    end
  end

  avalon_cdc_async_fifo #(
    .WIDTH       (DATA_W),
    .DEPTH       (RSP_DEPTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rsp_fifo (
    .wclk   (master_clk),
    .wrst_n (master_reset_n),
    .winc   (master_readdatavalid),
    .wdata  (master_readdata),
    .wfull  (rsp_full),
    .rclk   (slave_clk),
    .rrst_n (slave_reset_n),
    .rinc   (~rsp_empty),
    .rdata  (rsp_rdata),
    .rempty (rsp_empty)
  );

endmodule
